rom_table_streamer: RTL and testbench
=====================================

# rom_table_streamer

Read-side sequencer for the synchronous-read lookup ROMs used by the OLED path, such as the command and brightness tables. On a start pulse it walks addresses 0..TABLE_LEN-1 and accounts for the ROM's one-cycle registered read latency. Each entry is presented downstream on a valid/ready byte stream that feeds the OLED SPI sender. The block owns the ROM address bus; the ROM instance itself sits beside it at the top level.

## Interface
- DATA_WIDTH, 8, ROM word and stream data width
- ADDR_WIDTH, 8, ROM address width
- TABLE_LEN, 19, number of entries to stream; legal range 1..2**ADDR_WIDTH
- GAP_CYCLES, 4, idle cycles inserted after each accepted entry; used only when SEQ_GAP_EN is defined; 0 is legal
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- rom_addr  out  ADDR_WIDTH  registered address to the ROM
- rom_data  in  DATA_WIDTH  ROM output, valid one cycle after rom_addr is sampled
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  downstream ready
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse after the last entry is accepted

## Operation
- States: IDLE, FETCH, LATCH, SEND, and GAP (GAP exists only with SEQ_GAP_EN).
- IDLE: on start=1, load rom_addr<=0, set busy<=1, go to FETCH. Otherwise hold.
- FETCH: the ROM samples rom_addr on this edge. Go to LATCH.
- LATCH: m_data<=rom_data, m_valid<=1, go to SEND.
- SEND: hold m_data and m_valid until m_valid&&m_ready. On that edge:
  - drop m_valid.
  - If rom_addr==TABLE_LEN-1: pulse done, busy<=0, go to IDLE.
  - Otherwise rom_addr<=rom_addr+1, then go to GAP (if enabled and GAP_CYCLES>0) or to FETCH.
- GAP: count GAP_CYCLES cycles, then go to FETCH.
- The address compares against TABLE_LEN-1 at ADDR_WIDTH bits. It never wraps, because TABLE_LEN<=2**ADDR_WIDTH.
- abort has priority over every transition, including start and the handshake edge. On abort: m_valid<=0, busy<=0, no done, go to IDLE. A transfer pending on that edge is not counted as accepted.
- start while busy is ignored. A start coincident with done is not accepted; start is only sampled in IDLE.

## Timing
- Reset values:
  - rom_addr=0, m_data=0, m_valid=0, busy=0, done=0, state IDLE, gap counter 0.
- Reset mid-sequence forces the reset values immediately. No done is produced.
- start sampled at edge E0 gives:
  - busy=1 after E0.
  - m_valid=1 after E2 with m_data=entry 0.
- With m_ready held high, each entry takes 3 cycles, or 3+GAP_CYCLES with the gap enabled. A full sequence runs 3*TABLE_LEN cycles from E0 to the last handshake.
- done=1 for exactly the cycle after the final handshake edge. busy falls at the same edge.
- m_data is stable, and m_valid does not fall, while m_valid=1 and m_ready=0.

## Configuration
- SEQ_GAP_EN:
  - Defined: GAP state and a counter sized to hold GAP_CYCLES are compiled in, adding GAP_CYCLES idle cycles after every accepted entry except the last.
  - Undefined: GAP logic is absent, GAP_CYCLES is ignored, and SEND goes directly to FETCH.

## Test plan
- Reset and full stream: ROM loaded 0x00,0x06,0x07,...,0x5a (19 entries), m_ready=1, start pulse.
  - Required: 19 handshakes in address order 0x00..0x5a, spaced 3 cycles apart.
  - Required: done pulses once, 1 cycle after the 0x5a handshake; busy is high for the whole sequence.
- Backpressure: hold m_ready=0 for 5 cycles when m_data=0x2d (entry 9).
  - Required: m_valid and m_data=0x2d stay constant.
  - Required: entry 10 (0x3f) follows 3 cycles after ready returns.
- Abort: assert abort in SEND on entry 4 (0x09) while m_ready=1.
  - Required: no handshake is counted, m_valid=0, busy=0 and done=0 on the next cycle.
  - Required: a new start restarts from address 0 (0x00).
- Async reset during LATCH of entry 12.
  - Required: all outputs go to 0 immediately, with no clock edge needed.
  - Required: a later start streams from entry 0.
- Edge length and start rules: TABLE_LEN=1 streams only 0x00, then done. A start pulsed while busy=1 is ignored, and exactly 19 entries still stream.
- SEQ_GAP_EN with GAP_CYCLES=4, m_ready=1: handshakes are spaced 7 cycles apart, and done follows the last handshake with no gap.

Source files
------------

// File: rtl/rom_table_streamer.sv
// Read-side sequencer for a synchronous-read lookup ROM: walks addresses 0..TABLE_LEN-1
// and presents each entry on a valid/ready byte stream. Optional macro: SEQ_GAP_EN.
module rom_table_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TABLE_LEN  = 19,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Compared at ADDR_WIDTH bits; TABLE_LEN <= 2**ADDR_WIDTH so the address never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_LEN - 1);

`ifdef SEQ_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit GAP_ON = (GAP_CYCLES > 0);
`else
  // Gap logic is not built; GAP_CYCLES has no effect and GAP is unreachable.
  localparam bit GAP_ON = 1'b0 && (GAP_CYCLES > 0);
`endif

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SEQ_GAP_EN
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
`endif

  // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready are both
  // high. Once m_valid rises, m_valid and m_data hold until that edge; only abort or
  // reset may withdraw a beat, and a beat withdrawn by abort is not a transfer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SEQ_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        data_d  = rom_data;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = GAP_ON ? S_GAP : S_FETCH;
`ifdef SEQ_GAP_EN
            gap_cnt_d = GAP_LOAD;
`endif
          end
        end
      end
`ifdef SEQ_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_FETCH;
        else gap_cnt_d = gap_cnt_q - 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Abort wins over start and over a handshake on the same edge.
    if (abort) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
`ifdef SEQ_GAP_EN
      gap_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign rom_addr  = addr_q;
  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rom_table_streamer.sv
// Bench for rom_table_streamer: registered-read ROM model, scoreboard queue of expected
// stream bytes, and a second instance with TABLE_LEN=1.
module tb_rom_table_streamer;

  localparam int N   = 19;
  localparam int GAP = 4;
`ifdef SEQ_GAP_EN
  localparam int SPACING = 3 + GAP;
`else
  localparam int SPACING = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, m_ready;
  logic [7:0] rom_addr, rom_data, m_data;
  logic       m_valid, busy, done;
  logic [2:0] state_dbg;

  logic       start1, m_ready1;
  logic [7:0] rom_addr1, rom_data1, m_data1;
  logic       m_valid1, busy1, done1;
  logic [2:0] state_dbg1;

  logic [7:0] tbl [0:N-1] = '{8'h00, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0c, 8'h0e, 8'h1f,
                              8'h2d, 8'h3f, 8'h40, 8'h41, 8'h45, 8'h48, 8'h4c, 8'h50, 8'h55,
                              8'h5a};
  logic [7:0] rom [0:255];

  logic [7:0] exp_q[$];
  bit         last_q[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, prev_cyc = 0, hs_count = 0, done_cnt = 0;
  bit prev_ok = 0, stalled = 0, pend_done = 0;

  rom_table_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TABLE_LEN(N), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg));

  rom_table_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TABLE_LEN(1), .GAP_CYCLES(GAP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .busy(busy1), .done(done1), .state_dbg(state_dbg1));

  // Clock and ROM models.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data1 <= rom[rom_addr1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor: samples at the falling edge; a beat seen here transfers on the next rising edge.
  always @(negedge clk) begin
    logic [7:0] want;
    bit lst;
    if (!rst_n) begin
      pend_done = 0;
      prev_ok   = 0;
      stalled   = 0;
    end else begin
      check("done", done, pend_done);
      if (done) done_cnt++;
      pend_done = 0;
      if (m_valid && !m_ready) stalled = 1;
      if (m_valid && m_ready && !abort) begin
        hs_count++;
        check("busy_in_seq", busy, 1);
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          lst  = last_q.pop_front();
          check("data", m_data, want);
          pend_done = lst;
        end
        if (prev_ok && !stalled) check("spacing", cyc - prev_cyc, SPACING);
        prev_cyc = cyc;
        prev_ok  = 1;
        stalled  = 0;
      end
    end
  end

  task automatic start_seq();
    exp_q.delete();
    last_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(tbl[i]);
      last_q.push_back(i == N - 1);
    end
    hs_count = 0;
    prev_ok  = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit rnd_ready);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    check("done_seen", seen, 1);
    check("hs_count", hs_count, N);
    check("sb_empty", exp_q.size(), 0);
    check("busy_low", busy, 0);
  endtask

  task automatic wait_beat(input string tag, input logic [7:0] d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (m_valid && m_data == d) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < N; i++) rom[i] = tbl[i];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    start1 = 1'b0; m_ready1 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_data", m_data, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;

    // Full stream with ready held high
    start_seq();
    wait_done(1'b0);

    // Backpressure on entry 9
    start_seq();
    wait_beat("bp_find_08", 8'h1f);
    @(posedge clk); #1 m_ready = 1'b0;
    wait_beat("bp_find_09", 8'h2d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 8'h2d);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(1'b0);

    // Abort during SEND of entry 4, then restart from address 0
    start_seq();
    wait_beat("ab_find_04", 8'h09);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_valid", m_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_hs_count", hs_count, 4);
    start_seq();
    wait_done(1'b0);

    // Asynchronous reset during LATCH of entry 12
    start_seq();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (state_dbg == 3'd2 && rom_addr == 8'd12) begin
        ok = 1;
        break;
      end
    end
    check("rs_find_latch12", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_addr", rom_addr, 0);
    check("rs_data", m_data, 0);
    check("rs_valid", m_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_state", state_dbg, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    last_q.delete();
    start_seq();
    wait_done(1'b0);

    // Start pulsed while busy is ignored
    start_seq();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0);
    repeat (10) @(posedge clk);
    #1 check("idle_after_busy_start", busy, 0);

    // Random backpressure
    start_seq();
    wait_done(1'b1);

    // TABLE_LEN = 1
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_valid1) begin
        ok = 1;
        break;
      end
    end
    check("len1_valid", ok, 1);
    check("len1_data", m_data1, tbl[0]);
    check("len1_busy", busy1, 1);
    @(negedge clk);
    check("len1_done", done1, 1);
    check("len1_busy_low", busy1, 0);
    check("len1_valid_low", m_valid1, 0);
    @(negedge clk);
    check("len1_done_pulse", done1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
